// File: rtl/piano_pkg.sv
// Shared definitions for the song playback path: transport state codes,
// tempo divisor table and the rest (silence) note code.
package piano_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2
    } pb_state_e;

    localparam logic [3:0] NOTE_REST = 4'b0000;

    // Clocks of clk_5m per beat: 4, 5.33, 8 and 2.67 beats per second.
    localparam int unsigned TEMPO_DIV_0 = 32'd1250000;
    localparam int unsigned TEMPO_DIV_1 = 32'd937500;
    localparam int unsigned TEMPO_DIV_2 = 32'd625000;
    localparam int unsigned TEMPO_DIV_3 = 32'd1875000;

    // Beat length for a tempo index after the simulation speed-up shift.
    function automatic int unsigned tempo_div(input logic [1:0] sel,
                                              input int unsigned shift);
        int unsigned d;
        case (sel)
            2'd0:    d = TEMPO_DIV_0;
            2'd1:    d = TEMPO_DIV_1;
            2'd2:    d = TEMPO_DIV_2;
            default: d = TEMPO_DIV_3;
        endcase
        return d >> shift;
    endfunction

endpackage

// File: rtl/beat_gen.sv
// Beat divider: counts clk_5m cycles while running and flags the terminal
// cycle of each beat. The beat length is latched at PLAY entry and at every
// terminal, so a tempo change made mid-beat applies from the next beat.
// The terminal flag is combinational; the caller decides whether it turns
// into a beat tick (the last beat of a non-looping song ends in done instead).
module beat_gen
    import piano_pkg::*;
#(
    parameter int DIV_W     = 21,
    parameter int DIV_SHIFT = 0
) (
    input  logic       clk_5m,
    input  logic       rst_n,
    input  logic       run,
    input  logic       clear,
    input  logic       load,
    input  logic [1:0] tempo_sel,
    output logic       term
);

    localparam logic [DIV_W-1:0] LIM_RESET = DIV_W'(tempo_div(2'd0, DIV_SHIFT));

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [DIV_W-1:0] div_lim_q, div_lim_d;
    logic [DIV_W-1:0] lim_sel;

    // Terminal detection and next counter / limit values
    always_comb begin
        lim_sel   = DIV_W'(tempo_div(tempo_sel, DIV_SHIFT));
        term      = run && (div_cnt_q == div_lim_q - DIV_W'(1));
        div_cnt_d = div_cnt_q;
        div_lim_d = div_lim_q;
        if (clear) begin
            div_cnt_d = '0;
        end else if (run) begin
            div_cnt_d = term ? '0 : div_cnt_q + DIV_W'(1);
        end
        if (load || term) begin
            div_lim_d = lim_sel;
        end
    end

    // Counter and limit registers
    always_ff @(posedge clk_5m or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
            div_lim_q <= LIM_RESET;
        end else begin
            div_cnt_q <= div_cnt_d;
            div_lim_q <= div_lim_d;
        end
    end

endmodule

// File: rtl/song_playback_ctrl.sv
// Song transport and note-bus arbiter. Sequences the song ROM step address
// through play / pause / stop / loop at the selected tempo and drives the
// tone generator from the live keyboard when a key is held, otherwise from
// the song while playing, otherwise silence.
//
// state    | meaning
// ST_IDLE  | stopped, step rewound to 0, divider cleared
// ST_PLAY  | divider running, step advances on every beat terminal
// ST_PAUSE | divider and step frozen, cmd_play resumes where it left off
module song_playback_ctrl
    import piano_pkg::*;
#(
    parameter int SONG_LEN  = 236,
    parameter int STEP_W    = 10,
    parameter int DIV_W     = 21,
    parameter int DIV_SHIFT = 0
) (
    input  logic              clk_5m,
    input  logic              rst_n,
    input  logic              cmd_play,
    input  logic              cmd_pause,
    input  logic              cmd_stop,
    input  logic              loop_en,
    input  logic [1:0]        tempo_sel,
    input  logic [3:0]        key_med,
    input  logic [3:0]        key_low,
    input  logic [3:0]        song_med,
    input  logic [3:0]        song_low,
    output logic [STEP_W-1:0] song_step,
    output logic [3:0]        med,
    output logic [3:0]        low,
    output logic [1:0]        state,
    output logic              beat_tick,
    output logic              done
);

    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(SONG_LEN - 1);

    pb_state_e         state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [3:0]        med_q, med_d;
    logic [3:0]        low_q, low_d;
    logic              tick_q, tick_d;
    logic              done_q, done_d;

    logic              start;
    logic              bg_run;
    logic              bg_clear;
    logic              bg_term;
    logic              key_active;
    logic              last_step;

    // Command decode; stop outranks pause, pause outranks play. A terminal
    // landing on a stop or pause cycle is swallowed by dropping run.
    always_comb begin
        start      = (state_q == ST_IDLE) && cmd_play && !cmd_stop && !cmd_pause;
        bg_run     = (state_q == ST_PLAY) && !cmd_stop && !cmd_pause;
        bg_clear   = cmd_stop || (state_q == ST_IDLE);
        key_active = (key_med != NOTE_REST) || (key_low != NOTE_REST);
        last_step  = (step_q == LAST_STEP);
    end

    beat_gen #(
        .DIV_W     (DIV_W),
        .DIV_SHIFT (DIV_SHIFT)
    ) u_beat_gen (
        .clk_5m    (clk_5m),
        .rst_n     (rst_n),
        .run       (bg_run),
        .clear     (bg_clear),
        .load      (start),
        .tempo_sel (tempo_sel),
        .term      (bg_term)
    );

    // Transport FSM next state, step counter and one-cycle strobes
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        tick_d  = 1'b0;
        done_d  = 1'b0;
        if (cmd_stop) begin
            state_d = ST_IDLE;
            step_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_PLAY;
                        step_d  = '0;
                    end
                end
                ST_PLAY: begin
                    if (cmd_pause) begin
                        state_d = ST_PAUSE;
                    end else if (bg_term) begin
                        if (!last_step) begin
                            step_d = step_q + STEP_W'(1);
                            tick_d = 1'b1;
                        end else if (loop_en) begin
                            step_d = '0;
                            tick_d = 1'b1;
                        end else begin
                            // End of song: the final beat reports done, not a tick.
                            state_d = ST_IDLE;
                            step_d  = '0;
                            done_d  = 1'b1;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (cmd_play && !cmd_pause) begin
                        state_d = ST_PLAY;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    step_d  = '0;
                end
            endcase
        end
    end

    // Note bus arbitration: keyboard wins, song only while playing
    always_comb begin
        med_d = NOTE_REST;
        low_d = NOTE_REST;
        if (key_active) begin
            med_d = key_med;
            low_d = key_low;
        end else if (state_q == ST_PLAY) begin
            med_d = song_med;
            low_d = song_low;
        end
    end

    // State and output registers
    always_ff @(posedge clk_5m or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            step_q  <= '0;
            med_q   <= NOTE_REST;
            low_q   <= NOTE_REST;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            med_q   <= med_d;
            low_q   <= low_d;
            tick_q  <= tick_d;
            done_q  <= done_d;
        end
    end

    assign song_step = step_q;
    assign med       = med_q;
    assign low       = low_q;
    assign state     = state_q;
    assign beat_tick = tick_q;
    assign done      = done_q;

endmodule

// File: tb/tb_song_playback_ctrl.sv
// Scoreboard bench for song_playback_ctrl: the driver applies one input
// vector per cycle, advances a beat-level reference model and queues the
// expected outputs; the monitor pops and compares after each clock edge.
module tb_song_playback_ctrl;

    localparam int SONG_LEN  = 8;
    localparam int STEP_W    = 10;
    localparam int DIV_W     = 21;
    localparam int DIV_SHIFT = 16;

    logic              clk_5m = 1'b0;
    logic              rst_n  = 1'b1;
    logic              cmd_play = 1'b0, cmd_pause = 1'b0, cmd_stop = 1'b0;
    logic              loop_en = 1'b0;
    logic [1:0]        tempo_sel = 2'd0;
    logic [3:0]        key_med = 4'd0, key_low = 4'd0;
    logic [3:0]        song_med, song_low;
    logic [STEP_W-1:0] song_step;
    logic [3:0]        med, low;
    logic [1:0]        st;
    logic              beat_tick, done;

    logic [3:0] rom_med [SONG_LEN];
    logic [3:0] rom_low [SONG_LEN];

    song_playback_ctrl #(
        .SONG_LEN  (SONG_LEN),
        .STEP_W    (STEP_W),
        .DIV_W     (DIV_W),
        .DIV_SHIFT (DIV_SHIFT)
    ) dut (
        .clk_5m    (clk_5m),
        .rst_n     (rst_n),
        .cmd_play  (cmd_play),
        .cmd_pause (cmd_pause),
        .cmd_stop  (cmd_stop),
        .loop_en   (loop_en),
        .tempo_sel (tempo_sel),
        .key_med   (key_med),
        .key_low   (key_low),
        .song_med  (song_med),
        .song_low  (song_low),
        .song_step (song_step),
        .med       (med),
        .low       (low),
        .state     (st),
        .beat_tick (beat_tick),
        .done      (done)
    );

    always #100 clk_5m = ~clk_5m;

    // Combinational song ROM
    always_comb begin
        song_med = 4'd0;
        song_low = 4'd0;
        if (song_step < SONG_LEN) begin
            song_med = rom_med[song_step[2:0]];
            song_low = rom_low[song_step[2:0]];
        end
    end

    typedef struct {
        logic [STEP_W-1:0] step;
        logic [3:0]        med;
        logic [3:0]        low;
        logic [1:0]        st;
        logic              tick;
        logic              done;
    } exp_t;

    exp_t sb_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model: transport mode (0 idle, 1 play, 2 pause), song step,
    // and cycles remaining until the current beat ends.
    int   m_state = 0;
    int   m_step  = 0;
    int   m_rem   = 0;

    // Staged inputs, applied by drive_cycle at the falling edge
    bit       d_loop  = 1'b0;
    bit [1:0] d_tempo = 2'd0;
    bit [3:0] d_kmed  = 4'd0;
    bit [3:0] d_klow  = 4'd0;

    function automatic int beat_len(input bit [1:0] sel);
        case (sel)
            2'd0:    return 1250000 >> DIV_SHIFT;
            2'd1:    return 937500 >> DIV_SHIFT;
            2'd2:    return 625000 >> DIV_SHIFT;
            default: return 1875000 >> DIV_SHIFT;
        endcase
    endfunction

    task automatic compare(input string tag, input exp_t e);
        vectors++;
        if (song_step !== e.step || med !== e.med || low !== e.low ||
            st !== e.st || beat_tick !== e.tick || done !== e.done) begin
            miscompares++;
            $display("FAIL %s @%0t: got step=%0d st=%0d med=%0d low=%0d tick=%0b done=%0b, expected step=%0d st=%0d med=%0d low=%0d tick=%0b done=%0b",
                     tag, $time, song_step, st, med, low, beat_tick, done,
                     e.step, e.st, e.med, e.low, e.tick, e.done);
        end
    endtask

    // Advance the model across the coming clock edge using the applied inputs
    task automatic model_push();
        exp_t e;
        e.tick = 1'b0;
        e.done = 1'b0;
        if (key_med != 0 || key_low != 0) begin
            e.med = key_med;
            e.low = key_low;
        end else if (m_state == 1) begin
            e.med = rom_med[m_step];
            e.low = rom_low[m_step];
        end else begin
            e.med = 4'd0;
            e.low = 4'd0;
        end
        if (cmd_stop) begin
            m_state = 0;
            m_step  = 0;
        end else if (cmd_pause) begin
            if (m_state == 1) m_state = 2;
        end else if (cmd_play && m_state == 0) begin
            m_state = 1;
            m_step  = 0;
            m_rem   = beat_len(tempo_sel);
        end else if (cmd_play && m_state == 2) begin
            m_state = 1;
        end else if (m_state == 1) begin
            m_rem--;
            if (m_rem == 0) begin
                m_rem = beat_len(tempo_sel);
                if (m_step == SONG_LEN - 1) begin
                    m_step = 0;
                    if (loop_en) begin
                        e.tick = 1'b1;
                    end else begin
                        m_state = 0;
                        e.done  = 1'b1;
                    end
                end else begin
                    m_step++;
                    e.tick = 1'b1;
                end
            end
        end
        e.step = STEP_W'(m_step);
        e.st   = 2'(m_state);
        sb_q.push_back(e);
    endtask

    task automatic drive_cycle(input bit stp, input bit pse, input bit ply);
        @(negedge clk_5m);
        cmd_stop  = stp;
        cmd_pause = pse;
        cmd_play  = ply;
        loop_en   = d_loop;
        tempo_sel = d_tempo;
        key_med   = d_kmed;
        key_low   = d_klow;
        model_push();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 1'b0);
    endtask

    // Run until the next edge is a beat terminal, with a cycle budget
    task automatic run_to_boundary(input int budget);
        int n;
        n = 0;
        while (!(m_state == 1 && m_rem == 1)) begin
            if (n >= budget) begin
                vectors++;
                miscompares++;
                $display("FAIL boundary_wait: no beat terminal within %0d cycles", budget);
                return;
            end
            drive_cycle(1'b0, 1'b0, 1'b0);
            n++;
        end
    endtask

    task automatic check_zero(input string tag);
        exp_t z;
        z.step = '0; z.med = 4'd0; z.low = 4'd0; z.st = 2'd0; z.tick = 1'b0; z.done = 1'b0;
        compare(tag, z);
    endtask

    // Monitor: compare after every rising edge for which a vector was queued
    initial begin
        forever begin
            @(posedge clk_5m);
            #20;
            if (sb_q.size() > 0) compare("sb", sb_q.pop_front());
        end
    end

    initial begin
        for (int i = 0; i < SONG_LEN; i++) begin
            rom_med[i] = 4'($urandom_range(0, 12));
            rom_low[i] = 4'($urandom_range(0, 12));
        end
        rom_med[2] = 4'd0;
        rom_low[2] = 4'd0;

        // Reset state
        #50 rst_n = 1'b0;
        #300;
        check_zero("reset");
        @(negedge clk_5m);
        rst_n = 1'b1;

        // Tempo 0, full song without looping
        d_tempo = 2'd0;
        d_loop  = 1'b0;
        drive_cycle(1'b0, 1'b0, 1'b1);
        idle_cycles(8 * 19 + 10);

        // Looping play across the wrap
        d_loop = 1'b1;
        drive_cycle(1'b0, 1'b0, 1'b1);
        drive_cycle(1'b0, 1'b0, 1'b1);
        idle_cycles(8 * 19 + 30);

        // Pause at step 3 mid-beat, hold, resume
        drive_cycle(1'b1, 1'b0, 1'b0);
        drive_cycle(1'b0, 1'b0, 1'b1);
        idle_cycles(67);
        drive_cycle(1'b0, 1'b1, 1'b0);
        idle_cycles(50);
        drive_cycle(1'b0, 1'b1, 1'b1);
        drive_cycle(1'b0, 1'b0, 1'b1);
        idle_cycles(30);

        // Stop with play together, then stop and pause landing on terminals
        drive_cycle(1'b1, 1'b0, 1'b1);
        idle_cycles(5);
        drive_cycle(1'b0, 1'b0, 1'b1);
        run_to_boundary(100);
        drive_cycle(1'b1, 1'b0, 1'b0);
        idle_cycles(5);
        drive_cycle(1'b0, 1'b0, 1'b1);
        idle_cycles(3);
        run_to_boundary(100);
        drive_cycle(1'b0, 1'b1, 1'b0);
        idle_cycles(4);
        drive_cycle(1'b0, 1'b0, 1'b1);
        idle_cycles(25);

        // Keyboard override while playing, then in idle
        d_kmed = 4'd5;
        idle_cycles(30);
        d_kmed = 4'd0;
        idle_cycles(5);
        d_kmed = 4'd9;
        d_klow = 4'd3;
        idle_cycles(3);
        d_kmed = 4'd0;
        d_klow = 4'd0;
        drive_cycle(1'b1, 1'b0, 1'b0);
        d_klow = 4'd6;
        idle_cycles(3);
        d_klow = 4'd0;
        idle_cycles(2);

        // Tempo change mid-beat takes effect at the next boundary
        d_loop  = 1'b1;
        d_tempo = 2'd0;
        drive_cycle(1'b0, 1'b0, 1'b1);
        idle_cycles(5);
        d_tempo = 2'd2;
        idle_cycles(50);
        d_tempo = 2'd1;
        idle_cycles(40);
        d_tempo = 2'd3;
        idle_cycles(70);
        drive_cycle(1'b0, 1'b0, 1'b0);

        // Asynchronous reset while playing
        @(posedge clk_5m);
        #30 rst_n = 1'b0;
        #5;
        check_zero("async_reset");
        m_state = 0;
        m_step  = 0;
        cmd_play = 1'b0; cmd_pause = 1'b0; cmd_stop = 1'b0;
        @(negedge clk_5m);
        @(negedge clk_5m);
        rst_n = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 2500; i++) begin
            bit s, p, y;
            int r;
            s = ($urandom_range(0, 99) == 0);
            p = ($urandom_range(0, 39) == 0);
            y = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 49) == 0) d_tempo = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 199) == 0) d_loop = ~d_loop;
            if ($urandom_range(0, 24) == 0) begin
                r = $urandom_range(0, 3);
                if (r < 2) begin
                    d_kmed = 4'd0;
                    d_klow = 4'd0;
                end else if (r == 2) begin
                    d_kmed = 4'($urandom_range(1, 12));
                    d_klow = 4'd0;
                end else begin
                    d_kmed = 4'($urandom_range(0, 15));
                    d_klow = 4'($urandom_range(1, 15));
                end
            end
            drive_cycle(s, p, y);
        end
        idle_cycles(2);

        // Drain the scoreboard
        repeat (3) @(posedge clk_5m);
        #50;
        vectors++;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected vectors left unchecked, required 0", sb_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
